// File: rtl/seg_pkg.sv
// Shared types and constants for the SDRAM frame loader.
package seg_pkg;

    localparam int PIX_W  = 24;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    // Loader control states; the encoding is also visible on dbg_state.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FILL  = 3'd3,
        DONE  = 3'd4
    } loader_state_t;

    // Number of 32-bit words holding a packed RGB888 frame of w x h pixels.
    function automatic int nwords(input int w, input int h);
        return (w * h * 3) / 4;
    endfunction

endpackage

// File: rtl/byte_unpacker.sv
// Byte buffer that turns MSB-first 32-bit words into 24-bit {R,G,B} pixels
// and holds the pixel output register with its frame/line markers.
//
// Output handshake: a pixel transfers on every rising edge where pix_valid_o
// and pix_ready_i are both high. While pix_valid_o is high and pix_ready_i is
// low, pix_data_o and the markers hold their values.
module byte_unpacker
    import seg_pkg::*;
#(
    parameter int IMG_W = 224,
    parameter int IMG_H = 224
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    output logic [3:0]        count_o,
    output logic              handshake_o,
    output logic [PIX_W-1:0]  pix_data_o,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic              pix_sof_o,
    output logic              pix_eol_o,
    output logic              pix_eof_o
);

    localparam int X_W = $clog2(IMG_W + 1);
    localparam int Y_W = $clog2(IMG_H + 1);

    // Oldest byte sits in bytes_q[63:56]; bytes beyond the count are zero.
    logic [63:0]      bytes_q, bytes_d, bytes_pop;
    logic [3:0]       cnt_q, cnt_d, cnt_pop;
    logic [PIX_W-1:0] pix_q;
    logic             valid_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic             hs;
    logic             pop;

    // Pop three bytes into the output register first, then append a captured
    // word behind whatever remains, so push and pop in one cycle net +1.
    always_comb begin
        hs        = valid_q && pix_ready_i;
        pop       = (!valid_q || pix_ready_i) && (cnt_q >= 4'd3);
        bytes_pop = pop ? (bytes_q << 24) : bytes_q;
        cnt_pop   = pop ? (cnt_q - 4'd3) : cnt_q;
        bytes_d   = bytes_pop;
        cnt_d     = cnt_pop;
        if (push_i) begin
            bytes_d = bytes_pop | ({push_data_i, 32'h0} >> {cnt_pop, 3'b000});
            cnt_d   = cnt_pop + 4'd4;
        end
    end

    // Buffer, output register and the handshake-driven x/y position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bytes_q <= '0;
            cnt_q   <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (clear_i) begin
            bytes_q <= '0;
            cnt_q   <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            bytes_q <= bytes_d;
            cnt_q   <= cnt_d;
            if (pop) begin
                pix_q   <= bytes_q[63:40];
                valid_q <= 1'b1;
            end else if (hs) begin
                valid_q <= 1'b0;
            end
            if (hs) begin
                if (x_q == X_W'(IMG_W - 1)) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_W'(IMG_H - 1)) ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
        end
    end

    assign count_o     = cnt_q;
    assign handshake_o = hs;
    assign pix_data_o  = pix_q;
    assign pix_valid_o = valid_q;
    assign pix_sof_o   = valid_q && (x_q == '0) && (y_q == '0);
    assign pix_eol_o   = valid_q && (x_q == X_W'(IMG_W - 1));
    assign pix_eof_o   = valid_q && (x_q == X_W'(IMG_W - 1)) && (y_q == Y_W'(IMG_H - 1));

endmodule

// File: rtl/sdram_image_loader.sv
// Reads one packed RGB888 frame from SDRAM, one word in flight at a time,
// and streams it out as 24-bit pixels through byte_unpacker.
module sdram_image_loader
    import seg_pkg::*;
#(
    parameter int IMG_W      = 224,
    parameter int IMG_H      = 224,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_W     = 20,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sdram_addr,
    input  logic [WORD_W-1:0] sdram_data,
    output logic              sdram_we_n,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic [2:0]        dbg_state
);

    localparam int NWORDS = nwords(IMG_W, IMG_H);
    localparam int IDX_W  = $clog2(NWORDS + 1);
    localparam logic [IDX_W-1:0]  NWORDS_L = IDX_W'(NWORDS);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [2:0]        LAT_L    = 3'(RD_LATENCY);

    // Frames must split evenly into 32-bit words and the latency counter is 3 bits.
    if ((IMG_W * IMG_H) % 4 != 0) begin : g_bad_frame_size
        $error("sdram_image_loader: IMG_W*IMG_H must be divisible by 4");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("sdram_image_loader: RD_LATENCY must be in 1..4");
    end

    loader_state_t     state_q;
    logic [IDX_W-1:0]  word_idx_q;
    logic [2:0]        lat_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cmd_q;

    logic              clear;
    logic              push;
    logic [3:0]        count;
    logic              hs;

    // A new frame empties the unpacker; a word is captured RD_LATENCY edges
    // after the command edge.
    always_comb begin
        clear = (state_q == IDLE) && start;
        push  = (state_q == WAIT) && (lat_q == LAT_L);
    end

    // Loader FSM with registered strobes, address, busy and done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            lat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            cmd_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        word_idx_q <= '0;
                        busy_q     <= 1'b1;
                        addr_q     <= BASE_A;
                        cmd_q      <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_q   <= 1'b0;
                    lat_q   <= 3'd1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (lat_q == LAT_L) begin
                        word_idx_q <= word_idx_q + 1'b1;
                        state_q    <= FILL;
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                FILL: begin
                    // Room for another word is guaranteed once four or fewer bytes remain.
                    if (word_idx_q < NWORDS_L && count <= 4'd4) begin
                        addr_q  <= BASE_A + ADDR_W'(word_idx_q);
                        cmd_q   <= 1'b1;
                        state_q <= ISSUE;
                    end else if (word_idx_q == NWORDS_L && count == 4'd0 && hs && pix_eof) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    byte_unpacker #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_unpacker (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (clear),
        .push_i      (push),
        .push_data_i (sdram_data),
        .count_o     (count),
        .handshake_o (hs),
        .pix_data_o  (pix_data),
        .pix_valid_o (pix_valid),
        .pix_ready_i (pix_ready),
        .pix_sof_o   (pix_sof),
        .pix_eol_o   (pix_eol),
        .pix_eof_o   (pix_eof)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign sdram_addr  = addr_q;
    assign sdram_we_n  = 1'b1;
    assign sdram_cs_n  = ~cmd_q;
    assign sdram_ras_n = ~cmd_q;
    assign sdram_cas_n = ~cmd_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sdram_image_loader.sv
// Directed bench for sdram_image_loader: a 4x2 frame on two instances
// (latency 1 at base 0, latency 3 at base 16) against a strict-timing SDRAM model.
module tb_sdram_image_loader;

    localparam int AW    = 20;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];

    // Instance A signals
    logic          reset_n_a, start_a, ready_a;
    logic          busy_a, done_a, we_n_a, cs_n_a, ras_n_a, cas_n_a;
    logic [AW-1:0] addr_a;
    logic [31:0]   data_a;
    logic [23:0]   pix_a;
    logic          valid_a, sof_a, eol_a, eof_a;
    logic [2:0]    state_a;

    // Instance B signals
    logic          reset_n_b, start_b, ready_b;
    logic          busy_b, done_b, we_n_b, cs_n_b, ras_n_b, cas_n_b;
    logic [AW-1:0] addr_b;
    logic [31:0]   data_b;
    logic [23:0]   pix_b;
    logic          valid_b, sof_b, eol_b, eof_b;
    logic [2:0]    state_b;

    sdram_image_loader #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(0), .ADDR_W(AW), .RD_LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n_a), .start(start_a), .busy(busy_a), .done(done_a),
        .sdram_addr(addr_a), .sdram_data(data_a), .sdram_we_n(we_n_a), .sdram_cs_n(cs_n_a),
        .sdram_ras_n(ras_n_a), .sdram_cas_n(cas_n_a), .pix_data(pix_a), .pix_valid(valid_a),
        .pix_ready(ready_a), .pix_sof(sof_a), .pix_eol(eol_a), .pix_eof(eof_a), .dbg_state(state_a)
    );

    sdram_image_loader #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(16), .ADDR_W(AW), .RD_LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n_b), .start(start_b), .busy(busy_b), .done(done_b),
        .sdram_addr(addr_b), .sdram_data(data_b), .sdram_we_n(we_n_b), .sdram_cs_n(cs_n_b),
        .sdram_ras_n(ras_n_b), .sdram_cas_n(cas_n_b), .pix_data(pix_b), .pix_valid(valid_b),
        .pix_ready(ready_b), .pix_sof(sof_b), .pix_eol(eol_b), .pix_eof(eof_b), .dbg_state(state_b)
    );

    // Test memory: word i = {i, 40+i, 80+i, C0+i}, low 8 bits of each.
    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        logic [7:0] i;
        i = a[7:0];
        return {i, i + 8'h40, i + 8'h80, i + 8'hC0};
    endfunction

    // SDRAM models: data is valid only in the single cycle before the edge
    // RD_LATENCY edges after the command edge, garbage otherwise.
    logic          pend_a, pend_b;
    logic [2:0]    mcnt_a, mcnt_b;
    logic [AW-1:0] maddr_a, maddr_b;
    logic [AW-1:0] rd_q_a[$];
    logic [AW-1:0] rd_q_b[$];

    always @(posedge clk or negedge reset_n_a) begin
        if (!reset_n_a) begin
            pend_a <= 1'b0; mcnt_a <= 3'd0; maddr_a <= '0;
        end else if (!cs_n_a && !ras_n_a && !cas_n_a && we_n_a) begin
            pend_a <= 1'b1; mcnt_a <= 3'd0; maddr_a <= addr_a;
            rd_q_a.push_back(addr_a);
        end else if (pend_a) begin
            if (mcnt_a == 3'(LAT_A - 1)) pend_a <= 1'b0;
            else mcnt_a <= mcnt_a + 3'd1;
        end
    end
    assign data_a = (pend_a && mcnt_a == 3'(LAT_A - 1)) ? mem_word(maddr_a) : 32'hDEADBEEF;

    always @(posedge clk or negedge reset_n_b) begin
        if (!reset_n_b) begin
            pend_b <= 1'b0; mcnt_b <= 3'd0; maddr_b <= '0;
        end else if (!cs_n_b && !ras_n_b && !cas_n_b && we_n_b) begin
            pend_b <= 1'b1; mcnt_b <= 3'd0; maddr_b <= addr_b;
            rd_q_b.push_back(addr_b);
        end else if (pend_b) begin
            if (mcnt_b == 3'(LAT_B - 1)) pend_b <= 1'b0;
            else mcnt_b <= mcnt_b + 3'd1;
        end
    end
    assign data_b = (pend_b && mcnt_b == 3'(LAT_B - 1)) ? mem_word(maddr_b) : 32'hDEADBEEF;

    // Pixel/done monitors
    logic [23:0] pix_q_a[$];
    logic [2:0]  flg_q_a[$];
    logic [23:0] pix_q_b[$];
    int done_cnt_a, done_cyc_a, eof_cyc_a, done_cnt_b;

    always @(posedge clk) begin
        if (reset_n_a) begin
            if (valid_a && ready_a) begin
                pix_q_a.push_back(pix_a);
                flg_q_a.push_back({sof_a, eol_a, eof_a});
                if (eof_a) eof_cyc_a <= cyc;
            end
            if (done_a) begin
                done_cnt_a <= done_cnt_a + 1;
                done_cyc_a <= cyc;
            end
        end
        if (reset_n_b) begin
            if (valid_b && ready_b) pix_q_b.push_back(pix_b);
            if (done_b) done_cnt_b <= done_cnt_b + 1;
        end
    end

    task automatic load_frame_a();
        exp_q = {24'h004080, 24'hC00141, 24'h81C102, 24'h4282C2,
                 24'h034383, 24'hC30444, 24'h84C405, 24'h4585C5};
    endtask

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int d0, input string tag);
        int n;
        n = 0;
        while (done_cnt_a == d0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done_cnt_a == d0) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset();
        reset_n_a = 1'b0; reset_n_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
        checks++; if (addr_a !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr_a); end
        checks++; if ({we_n_a, cs_n_a, ras_n_a, cas_n_a} !== 4'b1111) begin
            errors++; $display("FAIL reset_strobes: got %b want 1111", {we_n_a, cs_n_a, ras_n_a, cas_n_a}); end
        checks++; if (valid_a !== 1'b0 || pix_a !== 24'h0) begin
            errors++; $display("FAIL reset_pix: got valid=%b data=%h want 0/000000", valid_a, pix_a); end
        checks++; if ({sof_a, eol_a, eof_a} !== 3'b000) begin
            errors++; $display("FAIL reset_markers: got %b want 000", {sof_a, eol_a, eof_a}); end
        checks++; if (state_a !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_a); end
        reset_n_a = 1'b1; reset_n_b = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        int d0;
        d0 = done_cnt_a;
        pulse_start_a();
        checks++; if ({cs_n_a, ras_n_a, cas_n_a, we_n_a} !== 4'b0001 || addr_a !== '0) begin
            errors++; $display("FAIL lat_cmd: got strobes=%b addr=%h want 0001/0",
                               {cs_n_a, ras_n_a, cas_n_a, we_n_a}, addr_a); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL lat_busy: got %b want 1", busy_a); end
        @(posedge clk); #1;
        checks++; if ({cs_n_a, ras_n_a, cas_n_a} !== 3'b111) begin
            errors++; $display("FAIL lat_cmd_end: got %b want 111", {cs_n_a, ras_n_a, cas_n_a}); end
        @(posedge clk); #1;
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b want 0", valid_a); end
        @(posedge clk); #1;
        checks++; if (valid_a !== 1'b1 || pix_a !== 24'h004080) begin
            errors++; $display("FAIL lat_first_pix: got valid=%b data=%h want 1/004080", valid_a, pix_a); end
        wait_done_a(d0, "lat");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame();
        int p0, r0, d0;
        p0 = pix_q_a.size(); r0 = rd_q_a.size(); d0 = done_cnt_a;
        load_frame_a();
        ready_a = 1'b1;
        pulse_start_a();
        wait_done_a(d0, "basic");
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rd_q_a.size() - r0 != 6) begin
            errors++; $display("FAIL basic_nreads: got %0d want 6", rd_q_a.size() - r0); end
        for (int i = 0; i < 6 && r0 + i < rd_q_a.size(); i++) begin
            checks++; if (rd_q_a[r0 + i] !== AW'(i)) begin
                errors++; $display("FAIL basic_addr%0d: got %h want %h", i, rd_q_a[r0 + i], AW'(i)); end
        end
        checks++; if (pix_q_a.size() - p0 != 8) begin
            errors++; $display("FAIL basic_npix: got %0d want 8", pix_q_a.size() - p0); end
        for (int i = 0; i < 8 && p0 + i < pix_q_a.size(); i++) begin
            logic [2:0] ef;
            ef = {i == 0, i == 3 || i == 7, i == 7};
            checks++; if (pix_q_a[p0 + i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_pix%0d: got %h want %h", i, pix_q_a[p0 + i], exp_q[i]); end
            checks++; if (flg_q_a[p0 + i] !== ef) begin
                errors++; $display("FAIL basic_flags%0d: got %b want %b", i, flg_q_a[p0 + i], ef); end
        end
        checks++; if (done_cnt_a - d0 != 1) begin
            errors++; $display("FAIL basic_ndone: got %0d want 1", done_cnt_a - d0); end
        checks++; if (done_cyc_a != eof_cyc_a + 1) begin
            errors++; $display("FAIL basic_done_time: got cycle %0d want %0d", done_cyc_a, eof_cyc_a + 1); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy_a); end
    endtask

    task automatic test_backpressure();
        int p0, d0, n, r_stall;
        p0 = pix_q_a.size(); d0 = done_cnt_a;
        load_frame_a();
        ready_a = 1'b0;
        pulse_start_a();
        n = 0;
        while (valid_a !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        r_stall = rd_q_a.size();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (valid_a !== 1'b1 || pix_a !== 24'h004080) begin
                errors++; $display("FAIL bp_hold%0d: got valid=%b data=%h want 1/004080", i, valid_a, pix_a); end
        end
        checks++; if (rd_q_a.size() - r_stall > 2) begin
            errors++; $display("FAIL bp_reads: got %0d reads while stalled want <=2", rd_q_a.size() - r_stall); end
        ready_a = 1'b1;
        wait_done_a(d0, "bp");
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pix_q_a.size() - p0 != 8) begin
            errors++; $display("FAIL bp_npix: got %0d want 8", pix_q_a.size() - p0); end
        for (int i = 0; i < 8 && p0 + i < pix_q_a.size(); i++) begin
            checks++; if (pix_q_a[p0 + i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_pix%0d: got %h want %h", i, pix_q_a[p0 + i], exp_q[i]); end
        end
    endtask

    task automatic test_start_while_busy();
        int p0, r0, d0;
        p0 = pix_q_a.size(); r0 = rd_q_a.size(); d0 = done_cnt_a;
        ready_a = 1'b1;
        pulse_start_a();
        repeat (8) @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL swb_busy: got %b want 1", busy_a); end
        pulse_start_a();
        wait_done_a(d0, "swb");
        repeat (30) @(posedge clk);
        #1;
        checks++; if (rd_q_a.size() - r0 != 6) begin
            errors++; $display("FAIL swb_nreads: got %0d want 6", rd_q_a.size() - r0); end
        checks++; if (pix_q_a.size() - p0 != 8) begin
            errors++; $display("FAIL swb_npix: got %0d want 8", pix_q_a.size() - p0); end
        checks++; if (done_cnt_a - d0 != 1) begin
            errors++; $display("FAIL swb_ndone: got %0d want 1", done_cnt_a - d0); end
    endtask

    task automatic test_reset_mid_frame();
        int p0, d0, n;
        p0 = pix_q_a.size();
        load_frame_a();
        ready_a = 1'b1;
        pulse_start_a();
        n = 0;
        while (pix_q_a.size() < p0 + 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        #2 reset_n_a = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || valid_a !== 1'b0 || pix_a !== 24'h0) begin
            errors++; $display("FAIL rst_mid_out: got busy=%b done=%b valid=%b data=%h want 0/0/0/000000",
                               busy_a, done_a, valid_a, pix_a); end
        checks++; if ({cs_n_a, ras_n_a, cas_n_a} !== 3'b111 || addr_a !== '0) begin
            errors++; $display("FAIL rst_mid_sdram: got strobes=%b addr=%h want 111/0",
                               {cs_n_a, ras_n_a, cas_n_a}, addr_a); end
        @(posedge clk); #1 reset_n_a = 1'b1;
        @(posedge clk); #1;
        p0 = pix_q_a.size(); d0 = done_cnt_a;
        pulse_start_a();
        wait_done_a(d0, "rst_mid");
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pix_q_a.size() - p0 != 8) begin
            errors++; $display("FAIL rst_mid_npix: got %0d want 8", pix_q_a.size() - p0); end
        if (pix_q_a.size() > p0) begin
            checks++; if (pix_q_a[p0] !== 24'h004080 || flg_q_a[p0] !== 3'b100) begin
                errors++; $display("FAIL rst_mid_first: got %h flags=%b want 004080/100", pix_q_a[p0], flg_q_a[p0]); end
        end
        for (int i = 1; i < 8 && p0 + i < pix_q_a.size(); i++) begin
            checks++; if (pix_q_a[p0 + i] !== exp_q[i]) begin
                errors++; $display("FAIL rst_mid_pix%0d: got %h want %h", i, pix_q_a[p0 + i], exp_q[i]); end
        end
    endtask

    task automatic test_latency_offset();
        int p0, r0, d0, n;
        logic [7:0]  bq[$];
        logic [31:0] w;
        p0 = pix_q_b.size(); r0 = rd_q_b.size(); d0 = done_cnt_b;
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            w = mem_word(AW'(16 + k));
            bq.push_back(w[31:24]); bq.push_back(w[23:16]);
            bq.push_back(w[15:8]);  bq.push_back(w[7:0]);
        end
        for (int p = 0; p < 8; p++) exp_q.push_back({bq[3*p], bq[3*p+1], bq[3*p+2]});
        ready_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        checks++; if (cs_n_b !== 1'b0 || addr_b !== AW'(16)) begin
            errors++; $display("FAIL off_first_addr: got cs_n=%b addr=%h want 0/10", cs_n_b, addr_b); end
        n = 0;
        while (valid_b !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL off_latency: got %0d edges want 5", n); end
        checks++; if (pix_b !== 24'h105090) begin
            errors++; $display("FAIL off_pix0: got %h want 105090", pix_b); end
        n = 0;
        while (done_cnt_b == d0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (done_cnt_b - d0 != 1) begin
            errors++; $display("FAIL off_done: got %0d done pulses want 1", done_cnt_b - d0); end
        checks++; if (rd_q_b.size() - r0 != 6) begin
            errors++; $display("FAIL off_nreads: got %0d want 6", rd_q_b.size() - r0); end
        for (int i = 0; i < 6 && r0 + i < rd_q_b.size(); i++) begin
            checks++; if (rd_q_b[r0 + i] !== AW'(16 + i)) begin
                errors++; $display("FAIL off_addr%0d: got %h want %h", i, rd_q_b[r0 + i], AW'(16 + i)); end
        end
        checks++; if (pix_q_b.size() - p0 != 8) begin
            errors++; $display("FAIL off_npix: got %0d want 8", pix_q_b.size() - p0); end
        for (int i = 0; i < 8 && p0 + i < pix_q_b.size(); i++) begin
            checks++; if (pix_q_b[p0 + i] !== exp_q[i]) begin
                errors++; $display("FAIL off_pix%0d: got %h want %h", i, pix_q_b[p0 + i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_basic_frame();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_frame();
        test_latency_offset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
